// File: rtl/dram_port_arbiter.sv
// Shares the single DRAM sequencer between the 68000 bus (port 0) and a DMA/video master (port 1).
// CPU has fixed priority, but DMA wins after MAX_CPU_STREAK CPU grants taken while DMA was waiting.
module dram_port_arbiter #(
  parameter int unsigned MAX_CPU_STREAK = 4
) (
  input  logic        CLK_ALT,
  input  logic        RST,
  input  logic        CPU_AS,
  input  logic        CPU_CS,
  input  logic        CPU_RW,
  input  logic        CPU_LDS,
  input  logic        CPU_UDS,
  input  logic [22:0] CPU_ADDR,
  output logic        CPU_DTACK,
  input  logic        DMA_REQ,
  input  logic        DMA_RW,
  input  logic [1:0]  DMA_BE,
  input  logic [22:0] DMA_ADDR,
  output logic        DMA_ACK,
  output logic        MEM_REQ,
  output logic [22:0] MEM_ADDR,
  output logic        MEM_RW,
  output logic        MEM_LDS,
  output logic        MEM_UDS,
  input  logic        MEM_ACK,
  input  logic        MEM_DONE
);

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_CPU_STREAK);

  typedef enum logic [2:0] {
    IDLE,
    GNT_CPU,
    GNT_DMA,
    END_CPU,
    RELEASE
  } state_t;

  state_t     state;
  logic       as1, as2, cs1, cs2;
  logic [3:0] streak;
  logic       cpu_req;
  logic       dma_wins;

  assign cpu_req  = ~as2 & ~cs2;
  assign dma_wins = DMA_REQ & (~cpu_req | (streak == STREAK_LIMIT));

  // NOTE: reset is synchronous here, so it sits inside the clocked branch rather than the
  // sensitivity list; every register below is plain logic, so all of them get a reset value.
  always_ff @(posedge CLK_ALT) begin
    if (!RST) begin
      state     <= IDLE;
      as1       <= 1'b1;
      as2       <= 1'b1;
      cs1       <= 1'b1;
      cs2       <= 1'b1;
      streak    <= '0;
      CPU_DTACK <= 1'b1;
      DMA_ACK   <= 1'b0;
      MEM_REQ   <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_RW    <= 1'b1;
      MEM_LDS   <= 1'b1;
      MEM_UDS   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments everywhere in this block, so every branch sees the
      // pre-edge values of state, streak and the synchroniser stages.
      as1     <= CPU_AS;
      as2     <= as1;
      cs1     <= CPU_CS;
      cs2     <= cs1;
      DMA_ACK <= 1'b0;

      case (state)
        IDLE: begin
          if (dma_wins) begin
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= DMA_ADDR;
            MEM_RW   <= DMA_RW;
            MEM_LDS  <= ~DMA_BE[0];
            MEM_UDS  <= ~DMA_BE[1];
            streak   <= '0;
            state    <= GNT_DMA;
          end else if (cpu_req) begin
            // CPU address and qualifiers are stable while AS is low, so they are taken unsynchronised.
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= CPU_ADDR;
            MEM_RW   <= CPU_RW;
            MEM_LDS  <= CPU_LDS;
            MEM_UDS  <= CPU_UDS;
            if (!DMA_REQ) begin
              streak <= '0;
            end else if (streak != STREAK_LIMIT) begin
              streak <= streak + 4'd1;
            end
            state <= GNT_CPU;
          end else if (!DMA_REQ) begin
            streak <= '0;
          end
        end

        GNT_CPU: begin
          CPU_DTACK <= ~MEM_ACK;
          if (MEM_ACK) begin
            state <= END_CPU;
          end
        end

        END_CPU: begin
          // Hold DTACK until the synchronised strobe shows the CPU has finished its cycle.
          if (as2) begin
            MEM_REQ   <= 1'b0;
            CPU_DTACK <= 1'b1;
            state     <= RELEASE;
          end else begin
            CPU_DTACK <= 1'b0;
          end
        end

        GNT_DMA: begin
          if (MEM_ACK) begin
            DMA_ACK <= 1'b1;
            MEM_REQ <= 1'b0;
            state   <= RELEASE;
          end
        end

        RELEASE: begin
          MEM_LDS <= 1'b1;
          MEM_UDS <= 1'b1;
          if (MEM_DONE) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed reset/CPU/DMA checks, then randomized CPU and DMA traffic against a sequencer model,
// with a scoreboard that predicts each grant from the arbitration rules and compares every cycle.
module tb_dram_port_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int N_CPU      = 80;
  localparam int N_DMA      = 30;

  logic        CLK_ALT = 1'b0;
  logic        RST;
  logic        CPU_AS, CPU_CS, CPU_RW, CPU_LDS, CPU_UDS;
  logic [22:0] CPU_ADDR;
  logic        CPU_DTACK;
  logic        DMA_REQ, DMA_RW;
  logic [1:0]  DMA_BE;
  logic [22:0] DMA_ADDR;
  logic        DMA_ACK;
  logic        MEM_REQ;
  logic [22:0] MEM_ADDR;
  logic        MEM_RW, MEM_LDS, MEM_UDS;
  logic        MEM_ACK, MEM_DONE;

  dram_port_arbiter #(.MAX_CPU_STREAK(MAX_STREAK)) dut (
    .CLK_ALT  (CLK_ALT),
    .RST      (RST),
    .CPU_AS   (CPU_AS),
    .CPU_CS   (CPU_CS),
    .CPU_RW   (CPU_RW),
    .CPU_LDS  (CPU_LDS),
    .CPU_UDS  (CPU_UDS),
    .CPU_ADDR (CPU_ADDR),
    .CPU_DTACK(CPU_DTACK),
    .DMA_REQ  (DMA_REQ),
    .DMA_RW   (DMA_RW),
    .DMA_BE   (DMA_BE),
    .DMA_ADDR (DMA_ADDR),
    .DMA_ACK  (DMA_ACK),
    .MEM_REQ  (MEM_REQ),
    .MEM_ADDR (MEM_ADDR),
    .MEM_RW   (MEM_RW),
    .MEM_LDS  (MEM_LDS),
    .MEM_UDS  (MEM_UDS),
    .MEM_ACK  (MEM_ACK),
    .MEM_DONE (MEM_DONE)
  );

  always #5 CLK_ALT = ~CLK_ALT;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK_ALT);
    #1;
  endtask

  // Expected bus word per transaction: {addr, rw, uds_n, lds_n}.
  logic [25:0] cpu_q[$];
  logic [25:0] dma_q[$];
  bit          rand_on   = 1'b0;
  bit          cpu_done  = 1'b0;
  bit          dma_done  = 1'b0;
  int          starve_hits = 0;

  // CPU request as seen two clock edges after the strobes move.
  logic sel_s1 = 1'b0;
  logic sel_s2 = 1'b0;
  always @(posedge CLK_ALT) begin
    if (!RST) begin
      sel_s1 <= 1'b0;
      sel_s2 <= 1'b0;
    end else begin
      sel_s1 <= ~CPU_AS & ~CPU_CS;
      sel_s2 <= sel_s1;
    end
  end

  // Scoreboard: compare this cycle, then predict what the coming edge must do.
  typedef enum {P_IDLE, P_CPU, P_DMA, P_REL} phase_t;
  phase_t      ph;
  logic        exp_req, exp_dtack, exp_dack, cpu_acked;
  logic [25:0] exp_bus;
  int          streak, rel_edges;

  initial begin : monitor
    wait (rand_on);
    ph = P_IDLE; exp_req = 1'b0; exp_dtack = 1'b1; exp_dack = 1'b0;
    cpu_acked = 1'b0; exp_bus = '0; streak = 0; rel_edges = 0;
    forever begin
      @(negedge CLK_ALT);
      check("mem_req", 32'(MEM_REQ), 32'(exp_req));
      check("cpu_dtack", 32'(CPU_DTACK), 32'(exp_dtack));
      check("dma_ack", 32'(DMA_ACK), 32'(exp_dack));
      if (ph == P_CPU || ph == P_DMA)
        check("mem_bus", 32'({MEM_ADDR, MEM_RW, MEM_UDS, MEM_LDS}), 32'(exp_bus));
      if (ph == P_REL && rel_edges >= 1)
        check("rel_strobes", 32'({MEM_UDS, MEM_LDS}), 32'(2'b11));

      exp_dack = 1'b0;
      case (ph)
        P_IDLE: begin
          if (DMA_REQ && (!sel_s2 || streak == MAX_STREAK)) begin
            if (streak == MAX_STREAK) starve_hits++;
            if (dma_q.size() == 0) check("dma_q_nonempty", 32'(dma_q.size()), 32'd1);
            else exp_bus = dma_q.pop_front();
            exp_req = 1'b1; streak = 0; ph = P_DMA;
          end else if (sel_s2) begin
            if (cpu_q.size() == 0) check("cpu_q_nonempty", 32'(cpu_q.size()), 32'd1);
            else exp_bus = cpu_q.pop_front();
            exp_req = 1'b1; cpu_acked = 1'b0; ph = P_CPU;
            streak = DMA_REQ ? ((streak < MAX_STREAK) ? streak + 1 : streak) : 0;
          end else begin
            streak = 0;
          end
        end
        P_CPU: begin
          if (!cpu_acked) begin
            exp_dtack = !MEM_ACK;
            cpu_acked = MEM_ACK;
          end else if (!sel_s2) begin
            exp_req = 1'b0; exp_dtack = 1'b1; rel_edges = 0; ph = P_REL;
          end else begin
            exp_dtack = 1'b0;
          end
        end
        P_DMA: begin
          if (MEM_ACK) begin
            exp_dack = 1'b1; exp_req = 1'b0; rel_edges = 0; ph = P_REL;
          end
        end
        P_REL: begin
          rel_edges++;
          if (MEM_DONE) ph = P_IDLE;
        end
      endcase
    end
  end

  // Sequencer model: ack after a random delay, hold until MEM_REQ falls, then precharge.
  initial begin : sequencer
    int t;
    wait (rand_on);
    forever begin
      @(negedge CLK_ALT);
      if (MEM_REQ) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK_ALT);
        step();
        MEM_ACK = 1'b1;
        t = 0;
        do begin @(negedge CLK_ALT); t++; end while (MEM_REQ && t < 400);
        check("req_drop_timeout", 32'(MEM_REQ), 32'd0);
        step();
        MEM_ACK = 1'b0;
        repeat (($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, 3)) @(posedge CLK_ALT);
        step();
        MEM_DONE = 1'b1;
        step();
        MEM_DONE = 1'b0;
      end
    end
  end

  initial begin : cpu_master
    logic [22:0] a;
    logic        rw;
    logic [1:0]  s;
    int          t;
    wait (rand_on);
    for (int n = 0; n < N_CPU; n++) begin
      repeat (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0) @(posedge CLK_ALT);
      step();
      a  = 23'($urandom);
      rw = 1'($urandom);
      s  = 2'($urandom_range(0, 2));
      CPU_ADDR = a; CPU_RW = rw; CPU_UDS = s[1]; CPU_LDS = s[0];
      CPU_AS = 1'b0; CPU_CS = 1'b0;
      cpu_q.push_back({a, rw, s});
      t = 0;
      do begin @(negedge CLK_ALT); t++; end while (CPU_DTACK && t < 500);
      check("cpu_dtack_timeout", 32'(CPU_DTACK), 32'd0);
      repeat ($urandom_range(0, 2)) @(posedge CLK_ALT);
      step();
      CPU_AS = 1'b1; CPU_CS = 1'b1;
      t = 0;
      do begin @(negedge CLK_ALT); t++; end while (!CPU_DTACK && t < 50);
      check("cpu_dtack_release", 32'(CPU_DTACK), 32'd1);
    end
    cpu_done = 1'b1;
  end

  initial begin : dma_master
    logic [22:0] a;
    logic        rw;
    logic [1:0]  be;
    int          t;
    wait (rand_on);
    for (int n = 0; n < N_DMA; n++) begin
      repeat ($urandom_range(0, 12)) @(posedge CLK_ALT);
      step();
      a  = 23'($urandom);
      rw = 1'($urandom);
      be = 2'($urandom_range(1, 3));
      DMA_ADDR = a; DMA_RW = rw; DMA_BE = be; DMA_REQ = 1'b1;
      dma_q.push_back({a, rw, ~be[1], ~be[0]});
      t = 0;
      do begin @(negedge CLK_ALT); t++; end while (!DMA_ACK && t < 1000);
      check("dma_ack_timeout", 32'(DMA_ACK), 32'd1);
      step();
      DMA_REQ = 1'b0;
    end
    dma_done = 1'b1;
  end

  initial begin : main
    int t;
    RST = 1'b0;
    CPU_AS = 1'b1; CPU_CS = 1'b1; CPU_RW = 1'b1; CPU_LDS = 1'b1; CPU_UDS = 1'b1; CPU_ADDR = '0;
    DMA_REQ = 1'b0; DMA_RW = 1'b1; DMA_BE = 2'b00; DMA_ADDR = '0;
    MEM_ACK = 1'b0; MEM_DONE = 1'b0;
    step();
    step();
    check("rst_dtack", 32'(CPU_DTACK), 32'd1);
    check("rst_dma_ack", 32'(DMA_ACK), 32'd0);
    check("rst_mem_req", 32'(MEM_REQ), 32'd0);
    check("rst_mem_bus", 32'({MEM_ADDR, MEM_RW, MEM_UDS, MEM_LDS}), 32'({23'h0, 3'b111}));
    RST = 1'b1;

    // CPU only: grant three edges after the strobes fall, DTACK after MEM_ACK.
    CPU_ADDR = 23'h012345; CPU_RW = 1'b1; CPU_LDS = 1'b0; CPU_UDS = 1'b0;
    CPU_AS = 1'b0; CPU_CS = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("cpu_latency_req", 32'(MEM_REQ), 32'(i == 3));
    end
    check("cpu_bus", 32'({MEM_ADDR, MEM_RW, MEM_UDS, MEM_LDS}), 32'({23'h012345, 3'b100}));
    MEM_ACK = 1'b1;
    step();
    check("cpu_dtack_low", 32'(CPU_DTACK), 32'd0);
    CPU_AS = 1'b1; CPU_CS = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("cpu_end_req", 32'(MEM_REQ), 32'(i < 3));
      check("cpu_end_dtack", 32'(CPU_DTACK), 32'(i == 3));
    end
    MEM_ACK = 1'b0;
    step();
    step();
    check("cpu_rel_strobes", 32'({MEM_UDS, MEM_LDS}), 32'(2'b11));
    MEM_DONE = 1'b1;
    step();
    MEM_DONE = 1'b0;
    step();
    check("cpu_idle_req", 32'(MEM_REQ), 32'd0);

    // DMA only: byte enables map to active-low strobes, one-cycle DMA_ACK.
    DMA_ADDR = 23'h400000; DMA_BE = 2'b01; DMA_RW = 1'b0; DMA_REQ = 1'b1;
    step();
    check("dma_req", 32'(MEM_REQ), 32'd1);
    check("dma_bus", 32'({MEM_ADDR, MEM_RW, MEM_UDS, MEM_LDS}), 32'({23'h400000, 3'b010}));
    MEM_ACK = 1'b1;
    step();
    check("dma_ack_pulse", 32'(DMA_ACK), 32'd1);
    check("dma_req_drop", 32'(MEM_REQ), 32'd0);
    MEM_ACK = 1'b0; DMA_REQ = 1'b0;
    step();
    check("dma_ack_single", 32'(DMA_ACK), 32'd0);
    MEM_DONE = 1'b1;
    step();
    MEM_DONE = 1'b0;
    step();

    // Reset in the middle of a DMA grant aborts without an ack.
    DMA_ADDR = 23'h1abcde; DMA_BE = 2'b11; DMA_RW = 1'b1; DMA_REQ = 1'b1;
    step();
    check("rstmid_granted", 32'(MEM_REQ), 32'd1);
    RST = 1'b0; MEM_ACK = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rstmid_no_ack", 32'(DMA_ACK), 32'd0);
    end
    check("rstmid_req", 32'(MEM_REQ), 32'd0);
    check("rstmid_dtack", 32'(CPU_DTACK), 32'd1);
    check("rstmid_bus", 32'({MEM_ADDR, MEM_RW, MEM_UDS, MEM_LDS}), 32'({23'h0, 3'b111}));
    RST = 1'b1; MEM_ACK = 1'b0; DMA_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid_idle_req", 32'(MEM_REQ), 32'd0);
      check("rstmid_idle_ack", 32'(DMA_ACK), 32'd0);
    end

    // Randomized mixed traffic against the scoreboard.
    rand_on = 1'b1;
    t = 0;
    while (!(cpu_done && dma_done) && t < 40000) begin
      @(posedge CLK_ALT);
      t++;
    end
    check("random_phase_done", 32'(cpu_done && dma_done), 32'd1);
    repeat (40) @(posedge CLK_ALT);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("dma_q_drained", 32'(dma_q.size()), 32'd0);
    check("starvation_seen", 32'(starve_hits > 0), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
